sram_sdi_responder: RTL and testbench
=====================================

Name: sram_sdi_responder

Overview:
- Synthesizable SPI/SDI serial-SRAM responder: the target side of the 23LC1024-style link the SRAM test master drives (EDIO 0x3B, WRITE 0x02, READ 0x03, 24-bit address, sequential mode).
- Oversamples sck/cs_n/d in its own fast clock and converts serial transactions into byte accesses on a simple synchronous RAM port.
- Used on the devboard and in simulation as a stand-in SRAM, so master-side tests run without the external part.

Parameters:
- ADDR_W, 17, implemented address bits; the low ADDR_W bits of the 24-bit address are used, the rest ignored.
- RD_LAT, 1, mem_rdata latency in clk cycles after mem_re (1 or 2).

Ports:
- clk  in  1  oversampling clock; must be >= 8x the sck frequency.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  serial clock from master, asynchronous to clk.
- cs  in  1  chip select from master, active low, asynchronous.
- d_in  in  2  sampled data pins; d_in[1] is the MSB in SDI.
- d_out  out  2  data pin drive values.
- d_oe  out  2  per-pin output enable; top level builds the inout.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  8  read byte, valid RD_LAT cycles after mem_re.
- sdi_mode  out  1  1 = dual (SDI) I/O mode active.
- busy  out  1  cs asserted and transaction in progress.
- cmd_err  out  1  sticky; set on an unsupported opcode, cleared by reset or by the next cs fall.

Behaviour:
- Reset values: d_out=0, d_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, sdi_mode=0, busy=0, cmd_err=0, state=IDLE.
- Synchronization: sck, cs and d_in pass through 2-FF synchronizers. Edges are detected on the synchronized sck.
- Sampling and drive: input is sampled on the detected rising sck edge. Output changes on the detected falling sck edge.
- Data width and order: bits per edge are 1 in SPI (d_in[0] in, d_out[1] out) and 2 in SDI (both pins, MSB pair first). A byte therefore takes 8 edges in SPI and 4 in SDI.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
- IDLE -> CMD on the synchronized cs fall. Clear the bit counter, clear cmd_err, set busy=1.
- CMD, on byte complete:
  - 0x3B: set sdi_mode=1, go to IGNORE.
  - 0xFF: set sdi_mode=0, go to IGNORE.
  - 0x02: go to ADDR (write).
  - 0x03: go to ADDR (read).
  - Any other opcode: set cmd_err=1, go to IGNORE.
- ADDR: shift in 24 bits MSB first, then latch the low ADDR_W bits into mem_addr.
  - Write: go to WDATA.
  - Read in SPI: pulse mem_re in the same cycle, go to RDATA.
  - Read in SDI: go to DUMMY.
- DUMMY (SDI read only): 4 rising edges are ignored. On the 4th, pulse mem_re and go to RDATA.
- WDATA: on each byte complete, mem_wdata=byte, mem_we=1 for one clk, then mem_addr increments on the next clk.
- RDATA:
  - RD_LAT clk after mem_re, mem_rdata is loaded into the output shift register. mem_addr increments, and mem_re pulses again to prefetch the next byte.
  - d_oe asserts on the first falling edge after entry (d_oe=2'b10 in SPI, 2'b11 in SDI). The first bits are presented on that edge.
  - When a byte is exhausted, the prefetched byte loads on the next falling edge with no gap.
- Address wrap: mem_addr wraps from 2^ADDR_W-1 to 0 in both directions of transfer.
- cs rise (synchronized) in any state: d_oe=0 and busy=0 in the same clk, return to IDLE. A partial write byte is discarded with no mem_we. sdi_mode is retained.
- sck edges while cs is high are ignored.
- An edge and a cs rise detected in the same clk: the cs rise wins, and the edge is not processed.
- Asynchronous reset mid-transaction: all outputs return to reset values immediately; the part returns to SPI mode.

Decomposition:
- Package sram_sdi_pkg holds:
  - opcode constants OP_EDIO=8'h3B, OP_RSTIO=8'hFF, OP_WRITE=8'h02, OP_READ=8'h03;
  - the state enum;
  - the address length constant 24.
- One sub-module, sdi_pin_sync: 2-FF synchronizers for sck, cs and d_in, plus rise/fall detect pulses for sck and cs.

Test Plan:
- SPI: send 0x3B -> sdi_mode=1 after cs rise, cmd_err=0, no mem_we/mem_re.
- SDI write 0x02, address 0x000010, data 0xA5,0x3C -> mem_we twice: addr 0x10 data 0xA5, then addr 0x11 data 0x3C.
- SDI read 0x03, address 0x000010, 1 dummy byte, 2 bytes clocked -> d_oe=2'b11 from the first post-dummy falling edge; pins return 0xA5 then 0x3C MSB pair first.
- Wrap: SDI write at address 0x01FFFF (ADDR_W=17), 2 bytes -> mem_we at 0x1FFFF then 0x00000.
- Abort: cs rise after 2 of 4 SDI data edges in WDATA -> no mem_we, d_oe=0, busy=0. The next transaction decodes normally.
- Opcode 0x55 -> cmd_err=1, no memory strobes. Asserting reset_n low mid-read forces d_oe=0 and sdi_mode=0 within the same clk.

Source files
------------

// File: rtl/sram_sdi_pkg.sv
// Shared opcodes, FSM encoding and the serial shift helper for the SPI/SDI serial-SRAM responder.
package sram_sdi_pkg;

   localparam int ADDR_LEN = 24;

   localparam logic [7:0] OP_EDIO  = 8'h3B;
   localparam logic [7:0] OP_RSTIO = 8'hFF;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_WDATA  = 3'd4,
      ST_RDATA  = 3'd5,
      ST_IGNORE = 3'd6
   } state_e;

   // Appends one edge worth of input bits: both pins in dual mode, d[0] only in single mode.
   function automatic logic [ADDR_LEN-1:0] shift_in(input logic [ADDR_LEN-1:0] sh,
                                                    input logic [1:0]          d,
                                                    input logic                dual);
      if (dual) begin
         return {sh[ADDR_LEN-3:0], d};
      end else begin
         return {sh[ADDR_LEN-2:0], d[0]};
      end
   endfunction

endpackage

// File: rtl/sram_sdi_responder_if.sv
// Byte-wide synchronous RAM port between the responder (master) and the memory array (slave).
interface sram_sdi_responder_if #(
   parameter int ADDR_W = 17
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata;

   modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re, input mem_rdata);
   modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re, output mem_rdata);
endinterface

// File: rtl/sdi_pin_sync.sv
// Two-stage synchronizers for the asynchronous serial pins plus single-cycle edge pulses.
module sdi_pin_sync (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sck,
   input  logic       cs,
   input  logic [1:0] d_in,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       cs_rise,
   output logic       cs_fall,
   output logic [1:0] d_s
);
   logic [2:0] sck_sync_q, sck_sync_d;
   logic [2:0] cs_sync_q,  cs_sync_d;
   logic [3:0] d_sync_q,   d_sync_d;

   // Stages 0-1 synchronize; stage 2 holds the previous value for edge detection.
   always_comb begin
      sck_sync_d = {sck_sync_q[1:0], sck};
      cs_sync_d  = {cs_sync_q[1:0], cs};
      d_sync_d   = {d_sync_q[1:0], d_in};
   end

   // Synchronizer flops; cs idles high so reset never looks like a select.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q <= 3'b000;
         cs_sync_q  <= 3'b111;
         d_sync_q   <= 4'b0000;
      end else begin
         sck_sync_q <= sck_sync_d;
         cs_sync_q  <= cs_sync_d;
         d_sync_q   <= d_sync_d;
      end
   end

   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
   assign d_s      = d_sync_q[3:2];

endmodule

// File: rtl/sram_sdi_responder.sv
// Serial-SRAM target: decodes SPI/SDI READ/WRITE/EDIO/RSTIO transactions into byte accesses
// on a synchronous RAM port, with read prefetch so sequential reads stream without gaps.
module sram_sdi_responder
   import sram_sdi_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sck,
   input  logic                 cs,
   input  logic [1:0]           d_in,
   output logic [1:0]           d_out,
   output logic [1:0]           d_oe,
   sram_sdi_responder_if.master mem,
   output logic                 sdi_mode,
   output logic                 busy,
   output logic                 cmd_err
);
   logic                sck_rise, sck_fall, cs_rise, cs_fall;
   logic [1:0]          d_s;
   state_e              state_q, state_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [1:0]          addr_byte_q, addr_byte_d;
   logic [ADDR_LEN-1:0] sh_q, sh_d, sh_nxt;
   logic                is_read_q, is_read_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          mem_wdata_q, mem_wdata_d;
   logic                mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic [RD_LAT-1:0]   re_dly_q, re_dly_d;
   logic [7:0]          out_sh_q, out_sh_d, pref_q, pref_d, src_s;
   logic [3:0]          edges_q, edges_d, per_byte_s;
   logic                got_first_q, got_first_d;
   logic [1:0]          d_out_q, d_out_d, d_oe_q, d_oe_d;
   logic                sdi_mode_q, sdi_mode_d, busy_q, busy_d, cmd_err_q, cmd_err_d;
   logic                rise_ev, fall_ev, byte_done;

   sdi_pin_sync u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .sck      (sck),
      .cs       (cs),
      .d_in     (d_in),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall),
      .d_s      (d_s)
   );

   // A cs rise in the same cycle as an sck edge suppresses the edge.
   always_comb begin
      rise_ev    = sck_rise & ~cs_rise;
      fall_ev    = sck_fall & ~cs_rise;
      sh_nxt     = shift_in(sh_q, d_s, sdi_mode_q);
      per_byte_s = sdi_mode_q ? 4'd4 : 4'd8;
      byte_done  = rise_ev && (bit_cnt_q == (sdi_mode_q ? 3'd3 : 3'd7));
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) state_d = ST_CMD;
               else         state_d = ST_IDLE;
            end
            ST_CMD: begin
               if (byte_done) begin
                  case (sh_nxt[7:0])
                     OP_WRITE, OP_READ: state_d = ST_ADDR;
                     default:           state_d = ST_IGNORE;
                  endcase
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_ADDR: begin
               if (byte_done && (addr_byte_q == 2'd2)) begin
                  if (!is_read_q)      state_d = ST_WDATA;
                  else if (sdi_mode_q) state_d = ST_DUMMY;
                  else                 state_d = ST_RDATA;
               end else begin
                  state_d = ST_ADDR;
               end
            end
            ST_DUMMY: begin
               if (byte_done) state_d = ST_RDATA;
               else           state_d = ST_DUMMY;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath and registered-output next values.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      addr_byte_d = addr_byte_q;
      sh_d        = sh_q;
      is_read_d   = is_read_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      re_dly_d    = RD_LAT'({re_dly_q, mem_re_q});
      out_sh_d    = out_sh_q;
      pref_d      = pref_q;
      src_s       = 8'h00;
      edges_d     = edges_q;
      got_first_d = got_first_q;
      d_out_d     = d_out_q;
      d_oe_d      = d_oe_q;
      sdi_mode_d  = sdi_mode_q;
      busy_d      = busy_q;
      cmd_err_d   = cmd_err_q;
      // Write address advances the cycle after the strobe.
      if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_W'(1);
      else          mem_addr_d = mem_addr_q;
      if (cs_rise) begin
         d_oe_d  = 2'b00;
         d_out_d = 2'b00;
         busy_d  = 1'b0;
      end else begin
         if (rise_ev && (state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA})) begin
            sh_d      = sh_nxt;
            bit_cnt_d = byte_done ? 3'd0 : bit_cnt_q + 3'd1;
         end else begin
            sh_d = sh_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_cnt_d = 3'd0;
                  cmd_err_d = 1'b0;
                  busy_d    = 1'b1;
               end else begin
                  busy_d = 1'b0;
               end
            end
            ST_CMD: begin
               if (byte_done) begin
                  addr_byte_d = 2'd0;
                  case (sh_nxt[7:0])
                     OP_EDIO:  sdi_mode_d = 1'b1;
                     OP_RSTIO: sdi_mode_d = 1'b0;
                     OP_WRITE: is_read_d  = 1'b0;
                     OP_READ:  is_read_d  = 1'b1;
                     default:  cmd_err_d  = 1'b1;
                  endcase
               end else begin
                  addr_byte_d = addr_byte_q;
               end
            end
            ST_ADDR: begin
               if (byte_done) begin
                  addr_byte_d = addr_byte_q + 2'd1;
                  if (addr_byte_q == 2'd2) begin
                     mem_addr_d  = sh_nxt[ADDR_W-1:0];
                     mem_re_d    = is_read_q && !sdi_mode_q;
                     edges_d     = 4'd0;
                     got_first_d = 1'b0;
                  end else begin
                     got_first_d = got_first_q;
                  end
               end else begin
                  addr_byte_d = addr_byte_q;
               end
            end
            ST_DUMMY: begin
               if (byte_done) mem_re_d = 1'b1;
               else           mem_re_d = 1'b0;
            end
            ST_WDATA: begin
               if (byte_done) begin
                  mem_wdata_d = sh_nxt[7:0];
                  mem_we_d    = 1'b1;
               end else begin
                  mem_we_d = 1'b0;
               end
            end
            ST_RDATA: begin
               // Exhausted byte is replaced by the prefetched one on the same falling edge.
               if (fall_ev) begin
                  if (edges_q == per_byte_s) begin
                     src_s    = pref_q;
                     edges_d  = 4'd1;
                     mem_re_d = 1'b1;
                  end else begin
                     src_s   = out_sh_q;
                     edges_d = edges_q + 4'd1;
                  end
                  d_oe_d   = sdi_mode_q ? 2'b11 : 2'b10;
                  d_out_d  = sdi_mode_q ? src_s[7:6] : {src_s[7], 1'b0};
                  out_sh_d = sdi_mode_q ? {src_s[5:0], 2'b00} : {src_s[6:0], 1'b0};
               end else begin
                  edges_d = edges_q;
               end
               if (re_dly_q[RD_LAT-1]) begin
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
                  if (!got_first_q) begin
                     out_sh_d    = mem.mem_rdata;
                     got_first_d = 1'b1;
                     mem_re_d    = 1'b1;
                  end else begin
                     pref_d = mem.mem_rdata;
                  end
               end else begin
                  pref_d = pref_q;
               end
            end
            default: busy_d = busy_q;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         addr_byte_q <= 2'd0;
         sh_q        <= '0;
         is_read_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         re_dly_q    <= '0;
         out_sh_q    <= 8'h00;
         pref_q      <= 8'h00;
         edges_q     <= 4'd0;
         got_first_q <= 1'b0;
         d_out_q     <= 2'b00;
         d_oe_q      <= 2'b00;
         sdi_mode_q  <= 1'b0;
         busy_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_byte_q <= addr_byte_d;
         sh_q        <= sh_d;
         is_read_q   <= is_read_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         re_dly_q    <= re_dly_d;
         out_sh_q    <= out_sh_d;
         pref_q      <= pref_d;
         edges_q     <= edges_d;
         got_first_q <= got_first_d;
         d_out_q     <= d_out_d;
         d_oe_q      <= d_oe_d;
         sdi_mode_q  <= sdi_mode_d;
         busy_q      <= busy_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign d_out         = d_out_q;
   assign d_oe          = d_oe_q;
   assign sdi_mode      = sdi_mode_q;
   assign busy          = busy_q;
   assign cmd_err       = cmd_err_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_sram_sdi_responder.sv
// Directed bench: a serial master drives transactions, a RAM model answers the byte port,
// and writes/reads are checked against queues filled when the stimulus is issued.
module tb_sram_sdi_responder;
   localparam int ADDR_W = 17;
   localparam int HALF   = 80;

   logic       clk = 1'b0;
   logic       reset_n, sck, cs;
   logic [1:0] d_in, d_out, d_oe;
   logic       sdi_mode, busy, cmd_err;
   int         checks = 0;
   int         errors = 0;
   int         we_cnt = 0;
   int         re_cnt = 0;
   logic [24:0] wr_q[$];
   logic [7:0]  rd_q[$];
   logic [7:0]  ram [0:(1<<ADDR_W)-1];

   sram_sdi_responder_if #(.ADDR_W(ADDR_W)) mem_if ();

   sram_sdi_responder #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .sck      (sck),
      .cs       (cs),
      .d_in     (d_in),
      .d_out    (d_out),
      .d_oe     (d_oe),
      .mem      (mem_if),
      .sdi_mode (sdi_mode),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle-latency RAM model.
   always @(posedge clk) begin
      if (mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
      if (mem_if.mem_re) mem_if.mem_rdata <= ram[mem_if.mem_addr];
   end

   // Strobe monitor and write scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_if.mem_re) re_cnt++;
      if (mem_if.mem_we) begin
         we_cnt++;
         if (wr_q.size() == 0)
            check("we_unexpected", {7'd0, mem_if.mem_addr, mem_if.mem_wdata}, 32'hFFFF_FFFF);
         else
            check("we_addr_data", {7'd0, mem_if.mem_addr, mem_if.mem_wdata}, {7'd0, wr_q.pop_front()});
      end
   end

   task automatic cs_begin();
      cs = 1'b0;
      #(HALF);
   endtask

   task automatic cs_end();
      #(HALF);
      cs = 1'b1;
      #(2 * HALF);
   endtask

   task automatic tx_group(input logic [1:0] v);
      d_in = v;
      #(HALF);
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
   endtask

   task automatic tx_byte(input logic [7:0] b, input logic dual);
      if (dual) begin
         for (int i = 3; i >= 0; i--) tx_group(b[2*i+1 -: 2]);
      end else begin
         for (int i = 7; i >= 0; i--) tx_group({1'b0, b[i]});
      end
   endtask

   task automatic rx_byte(input logic dual, input string tag);
      logic [7:0] got = 8'h00;
      int         n   = dual ? 4 : 8;
      for (int i = 0; i < n; i++) begin
         #(HALF);
         if (i == 0) check({tag, "_oe"}, 32'(d_oe), dual ? 32'd3 : 32'd2);
         got = dual ? {got[5:0], d_out} : {got[6:0], d_out[1]};
         sck = 1'b1;
         #(HALF);
         sck = 1'b0;
      end
      check(tag, 32'(got), 32'(rd_q.pop_front()));
   endtask

   initial begin
      int we0, re0;
      reset_n = 1'b0;
      sck     = 1'b0;
      cs      = 1'b1;
      d_in    = 2'b00;
      #23;
      check("rst_d_oe", 32'(d_oe), 32'd0);
      check("rst_d_out", 32'(d_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sdi_mode", 32'(sdi_mode), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
      check("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
      reset_n = 1'b1;
      #40;

      // SPI EDIO switches to dual mode without touching memory.
      we0 = we_cnt; re0 = re_cnt;
      cs_begin();
      check("edio_busy", 32'(busy), 32'd1);
      tx_byte(8'h3B, 1'b0);
      cs_end();
      check("edio_sdi_mode", 32'(sdi_mode), 32'd1);
      check("edio_cmd_err", 32'(cmd_err), 32'd0);
      check("edio_busy_off", 32'(busy), 32'd0);
      check("edio_no_we", 32'(we_cnt - we0), 32'd0);
      check("edio_no_re", 32'(re_cnt - re0), 32'd0);

      // SDI write of two bytes at 0x10.
      wr_q.push_back({17'h00010, 8'hA5});
      wr_q.push_back({17'h00011, 8'h3C});
      cs_begin();
      tx_byte(8'h02, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h10, 1'b1);
      tx_byte(8'hA5, 1'b1); tx_byte(8'h3C, 1'b1);
      cs_end();
      check("wr_pending", 32'(wr_q.size()), 32'd0);

      // SDI read back with one dummy byte.
      rd_q.push_back(8'hA5);
      rd_q.push_back(8'h3C);
      cs_begin();
      tx_byte(8'h03, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h10, 1'b1);
      tx_byte(8'h00, 1'b1);
      rx_byte(1'b1, "sdi_rd0");
      rx_byte(1'b1, "sdi_rd1");
      cs_end();
      check("sdi_rd_oe_off", 32'(d_oe), 32'd0);

      // Write across the top of the address space.
      wr_q.push_back({17'h1FFFF, 8'h5A});
      wr_q.push_back({17'h00000, 8'hC3});
      cs_begin();
      tx_byte(8'h02, 1'b1); tx_byte(8'h01, 1'b1); tx_byte(8'hFF, 1'b1); tx_byte(8'hFF, 1'b1);
      tx_byte(8'h5A, 1'b1); tx_byte(8'hC3, 1'b1);
      cs_end();
      check("wrap_pending", 32'(wr_q.size()), 32'd0);

      // Abort half-way through a data byte, then a normal write.
      we0 = we_cnt;
      cs_begin();
      tx_byte(8'h02, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h01, 1'b1); tx_byte(8'h00, 1'b1);
      tx_group(2'b11);
      tx_group(2'b01);
      cs_end();
      check("abort_no_we", 32'(we_cnt - we0), 32'd0);
      check("abort_d_oe", 32'(d_oe), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      wr_q.push_back({17'h00020, 8'h77});
      cs_begin();
      tx_byte(8'h02, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h20, 1'b1);
      tx_byte(8'h77, 1'b1);
      cs_end();
      check("post_abort_pending", 32'(wr_q.size()), 32'd0);

      // Unsupported opcode.
      we0 = we_cnt; re0 = re_cnt;
      cs_begin();
      tx_byte(8'h55, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h10, 1'b1);
      cs_end();
      check("badop_cmd_err", 32'(cmd_err), 32'd1);
      check("badop_sdi_mode", 32'(sdi_mode), 32'd1);
      check("badop_no_we", 32'(we_cnt - we0), 32'd0);
      check("badop_no_re", 32'(re_cnt - re0), 32'd0);

      // Next select clears cmd_err; reset lands in the middle of the read.
      rd_q.push_back(8'hA5);
      cs_begin();
      check("cmd_err_cleared", 32'(cmd_err), 32'd0);
      tx_byte(8'h03, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h00, 1'b1); tx_byte(8'h10, 1'b1);
      tx_byte(8'h00, 1'b1);
      rx_byte(1'b1, "pre_rst_rd");
      check("pre_rst_oe", 32'(d_oe), 32'd3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_d_oe", 32'(d_oe), 32'd0);
      check("mid_rst_sdi_mode", 32'(sdi_mode), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      cs = 1'b1;
      #39;
      reset_n = 1'b1;
      #(2 * HALF);

      // SPI read wrapping from the last address to zero.
      rd_q.push_back(8'h5A);
      rd_q.push_back(8'hC3);
      cs_begin();
      tx_byte(8'h03, 1'b0); tx_byte(8'h01, 1'b0); tx_byte(8'hFF, 1'b0); tx_byte(8'hFF, 1'b0);
      rx_byte(1'b0, "spi_rd0");
      rx_byte(1'b0, "spi_rd1");
      cs_end();
      check("spi_rd_oe_off", 32'(d_oe), 32'd0);
      check("rd_pending", 32'(rd_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
